fmap_collector: RTL and testbench

Receiving end of a layer's pooled output stream. Captures each `data_in` beat qualified by `data_valid` into a DIM×DIM feature-map buffer in raster order. Signals frame completion and holds the frame for readback by the next layer or the host. Instantiated downstream of each `layer_N`, one per output channel.

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/fmap_ram.sv | 42 ++++
 rtl/fmap_collector.sv | 121 ++++++++++++
 tb/tb_fmap_collector.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and defaults for the CNN layer blocks.
//   fmap_state_t - collector FSM states {IDLE, FILL, DONE}
//   OP_DEF       - default sample MSB index (samples are signed [OP:0])
//   L1_DIM/L2_DIM- per-layer feature-map edge lengths
//   clog2_dim    - address width for a DIM x DIM buffer (minimum 1)
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fmap_state_t;

  localparam int OP_DEF = 8;
  localparam int L1_DIM = 10;
  localparam int L2_DIM = 5;

  function automatic int clog2_dim(input int dim);
    return (dim * dim > 1) ? $clog2(dim * dim) : 1;
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// fmap_ram: DEPTH x (OP+1) feature-map buffer, one write port and one
// registered read port. A read and write to the same address in the same
// cycle returns the previous contents. Out-of-range reads return 0.
//   clk, reset        - clock, synchronous active-high reset (read reg only)
//   we/wr_addr/wr_data- write port
//   rd_en/rd_addr     - read request; rd_data valid the following cycle
//   rd_data           - registered read data (holds when rd_en is low)
module fmap_ram #(
  parameter int OP    = 8,
  parameter int DEPTH = 25,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [OP:0]   wr_data,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [OP:0]   rd_data
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic signed [OP:0] mem [DEPTH];

  // No reset on the array: contents survive reset by design.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Non-blocking read of mem gives read-before-write on collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if ({1'b0, rd_addr} < DEPTH_W) rd_data <= mem[rd_addr];
      else                           rd_data <= '0;
    end
  end

endmodule

// File: rtl/fmap_collector.sv
// fmap_collector: captures a DIM x DIM pooled feature map in raster order,
// pulses frame_done on completion and holds the frame until frame_release.
// Optional build macro: FMAP_COLLECTOR_RELU_EN stores negative samples as 0.
//   clk, reset            - clock, synchronous active-high reset
//   data_in, data_valid   - incoming sample stream
//   frame_release         - frees the held frame (only acts in DONE)
//   rd_en, rd_addr        - readback request (row*DIM + col)
//   rd_data, rd_valid     - readback result, one cycle after rd_en
//   frame_done            - one-cycle pulse, first cycle in DONE
//   busy                  - high while in FILL
//   overflow              - sticky, a sample arrived in DONE and was dropped
//
// state | meaning
// IDLE  | empty, waiting for element 0
// FILL  | capturing elements 1..DIM*DIM-1
// DONE  | frame complete and held; new samples dropped
module fmap_collector
  import cnn_pkg::*;
#(
  parameter int OP  = OP_DEF,
  parameter int DIM = L2_DIM,
  parameter int AW  = clog2_dim(DIM)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [OP:0]   data_in,
  input  logic                 data_valid,
  input  logic                 frame_release,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [OP:0]   rd_data,
  output logic                 rd_valid,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overflow
);

  localparam logic [AW-1:0] EDGE_LAST = AW'(DIM - 1);

  fmap_state_t        state;
  logic [AW-1:0]      count;
  logic [AW-1:0]      row;
  logic [AW-1:0]      col;
  logic               accept;
  logic               last;
  logic signed [OP:0] wr_data;

  // count/row/col are zero in IDLE and DONE, so count is always the
  // write address, including element 0 taken on a release in DONE.
  assign accept = data_valid && ((state != DONE) || frame_release);
  assign last   = (row == EDGE_LAST) && (col == EDGE_LAST);

  always_comb begin
    wr_data = data_in;
`ifdef FMAP_COLLECTOR_RELU_EN
    if (data_in[OP]) wr_data = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      row        <= '0;
      col        <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        if (last) begin
          state      <= DONE;
          count      <= '0;
          row        <= '0;
          col        <= '0;
          frame_done <= 1'b1;
          busy       <= 1'b0;
        end else begin
          state <= FILL;
          count <= count + AW'(1);
          busy  <= 1'b1;
          if (col == EDGE_LAST) begin
            col <= '0;
            row <= row + AW'(1);
          end else begin
            col <= col + AW'(1);
          end
        end
      end else if (state == DONE) begin
        if (frame_release) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (data_valid) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_valid <= 1'b0;
    else       rd_valid <= rd_en;
  end

  fmap_ram #(
    .OP    (OP),
    .DEPTH (DIM * DIM),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (accept),
    .wr_addr (count),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_fmap_collector.sv
module tb_fmap_collector;

  localparam int OP  = 8;
  localparam int DIM = 5;
  localparam int AW  = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [OP:0]  data_in;
  logic                data_valid;
  logic                frame_release;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic signed [OP:0]  rd_data;
  logic                rd_valid;
  logic                frame_done;
  logic                busy;
  logic                overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fmap_collector #(.OP(OP), .DIM(DIM), .AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .frame_release (frame_release),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .frame_done    (frame_done),
    .busy          (busy),
    .overflow      (overflow)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [OP:0] v);
    data_valid = 1'b1;
    data_in    = v;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    data_in = '0; data_valid = 1'b0; frame_release = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    do_reset();
    checks++; if (rd_data !== 9'sd0) begin errors++; $display("FAIL reset_rd_data got %0d exp 0", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_fill();
    logic signed [OP:0] v;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      v = 9'(i - 12);
      push(v);
      checks++;
      if (frame_done !== (i == 24)) begin
        errors++; $display("FAIL fill_frame_done idx %0d got %b exp %b", i, frame_done, (i == 24));
      end
      checks++;
      if (busy !== (i < 24)) begin
        errors++; $display("FAIL fill_busy idx %0d got %b exp %b", i, busy, (i < 24));
      end
    end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL fill_done_width got %b exp 0", frame_done); end
    rd(5'd0);
    checks++; if (rd_valid !== 1'b1 || rd_data !== -9'sd12) begin errors++; $display("FAIL fill_rd0 got %0d/%b exp -12/1", rd_data, rd_valid); end
    rd(5'd12);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 9'sd0) begin errors++; $display("FAIL fill_rd12 got %0d/%b exp 0/1", rd_data, rd_valid); end
    rd(5'd24);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 9'sd12) begin errors++; $display("FAIL fill_rd24 got %0d/%b exp 12/1", rd_data, rd_valid); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fill_rd_valid_drop got %b exp 0", rd_valid); end
  endtask

  task automatic test_gapped_overflow();
    int fd_cnt = 0;
    logic signed [OP:0] v;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      v = 9'(20 + i);
      push(v);
      if (frame_done) fd_cnt++;
      checks++;
      if (busy !== (i < 24)) begin errors++; $display("FAIL gap_busy idx %0d got %b exp %b", i, busy, (i < 24)); end
      if (i < 24) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          if (frame_done) fd_cnt++;
          checks++;
          if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy_idle idx %0d got %b exp 1", i, busy); end
        end
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL gap_ovf_early got %b exp 0", overflow); end
    push(-9'sd1);
    if (frame_done) fd_cnt++;
    push(-9'sd2);
    if (frame_done) fd_cnt++;
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL gap_done_count got %0d exp 1", fd_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL gap_overflow got %b exp 1", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy_done got %b exp 0", busy); end
    rd(5'd0);
    checks++; if (rd_data !== 9'sd20) begin errors++; $display("FAIL gap_rd0 got %0d exp 20", rd_data); end
    rd(5'd24);
    checks++; if (rd_data !== 9'sd44) begin errors++; $display("FAIL gap_rd24 got %0d exp 44", rd_data); end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL gap_overflow_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_release_same_cycle();
    do_reset();
    for (int i = 0; i < 25; i++) push(9'(i));
    frame_release = 1'b1;
    push(9'sd7);
    frame_release = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rel_busy got %b exp 1", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rel_overflow got %b exp 0", overflow); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rel_frame_done got %b exp 0", frame_done); end
    rd(5'd0);
    checks++; if (rd_data !== 9'sd7) begin errors++; $display("FAIL rel_rd0 got %0d exp 7", rd_data); end
    rd(5'd1);
    checks++; if (rd_data !== 9'sd1) begin errors++; $display("FAIL rel_rd1_old got %0d exp 1", rd_data); end
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rel_ignored_in_fill got %b exp 1", busy); end
    push(9'sd8);
    rd(5'd1);
    checks++; if (rd_data !== 9'sd8) begin errors++; $display("FAIL rel_next_elem got %0d exp 8", rd_data); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int i = 0; i < 10; i++) push(9'sd8);
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after_reset got %b exp 0", busy); end
    for (int i = 0; i < 25; i++) begin
      push(9'sd3);
      checks++;
      if (frame_done !== (i == 24)) begin
        errors++; $display("FAIL mid_frame_done idx %0d got %b exp %b", i, frame_done, (i == 24));
      end
    end
    for (int a = 0; a < 25; a++) begin
      rd(5'(a));
      checks++;
      if (rd_data !== 9'sd3 || rd_valid !== 1'b1) begin
        errors++; $display("FAIL mid_rd addr %0d got %0d/%b exp 3/1", a, rd_data, rd_valid);
      end
    end
  endtask

  task automatic test_relu();
    logic signed [OP:0] exp_v;
`ifdef FMAP_COLLECTOR_RELU_EN
    exp_v = 9'sd0;
`else
    exp_v = -9'sd5;
`endif
    do_reset();
    push(-9'sd5);
    push(9'sd6);
    rd(5'd0);
    checks++; if (rd_data !== exp_v) begin errors++; $display("FAIL relu_rd0 got %0d exp %0d", rd_data, exp_v); end
    rd(5'd1);
    checks++; if (rd_data !== 9'sd6) begin errors++; $display("FAIL relu_rd1 got %0d exp 6", rd_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL relu_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_collision_oor();
    do_reset();
    for (int i = 0; i < 25; i++) push(9'sd2);
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL col_idle_busy got %b exp 0", busy); end
    for (int i = 0; i < 4; i++) push(9'sd9);
    rd_en = 1'b1; rd_addr = 5'd4;
    push(9'sd9);
    rd_en = 1'b0;
    checks++; if (rd_data !== 9'sd2) begin errors++; $display("FAIL col_read_old got %0d exp 2", rd_data); end
    rd(5'd4);
    checks++; if (rd_data !== 9'sd9) begin errors++; $display("FAIL col_read_new got %0d exp 9", rd_data); end
    rd(5'd25);
    checks++; if (rd_data !== 9'sd0 || rd_valid !== 1'b1) begin errors++; $display("FAIL oor_25 got %0d/%b exp 0/1", rd_data, rd_valid); end
    rd(5'd3);
    rd(5'd31);
    checks++; if (rd_data !== 9'sd0 || rd_valid !== 1'b1) begin errors++; $display("FAIL oor_31 got %0d/%b exp 0/1", rd_data, rd_valid); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_gapped_overflow();
    test_release_same_cycle();
    test_reset_mid_frame();
    test_relu();
    test_collision_oor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
